capture_ctrl: RTL and testbench

- Parametrised successor to the free-running burst generator on the ADC capture path.
- Arms on software command and starts a burst on a trigger.
- Each burst delivers a programmable number of samples to the Xillybus write FIFO, taken either from the ADC or from an internal ramp test pattern.
- Supports single-shot or continuous bursts with a programmable gap; FIFO back-pressure causes samples to be dropped and flagged, never stalled.

---
 rtl/capture_pkg.sv | 22 ++
 rtl/capture_ctrl_if.sv | 30 +++
 rtl/capture_ramp_gen.sv | 30 +++
 rtl/capture_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_capture_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/capture_pkg.sv
// -----------------------------------------------------------------------------
// capture_pkg
//   Shared types and constants for the ADC capture controller slice.
//   - state_t            : capture FSM states
//   - MODE_ADC/MODE_RAMP : sample source select encodings
//   - BURST_LEN_DEFAULT  : burst length used when burst_len is programmed to 0
// -----------------------------------------------------------------------------
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic MODE_ADC  = 1'b0;
    localparam logic MODE_RAMP = 1'b1;

    localparam int unsigned BURST_LEN_DEFAULT = 16384;

endpackage

// File: rtl/capture_ctrl_if.sv
// -----------------------------------------------------------------------------
// capture_ctrl_if
//   Write-side bus from the capture controller into the Xillybus write FIFO.
//   Ports / signals:
//     dv        : output word valid (FIFO write enable), driven by master
//     data      : output word, DATA_W bits, driven by master
//     fifo_full : downstream FIFO full, driven by slave
//   Modports: master (capture controller), slave (FIFO side).
// -----------------------------------------------------------------------------
interface capture_ctrl_if #(
    parameter int unsigned DATA_W = 16
) ();

    logic              dv;
    logic [DATA_W-1:0] data;
    logic              fifo_full;

    modport master (
        output dv,
        output data,
        input  fifo_full
    );

    modport slave (
        input  dv,
        input  data,
        output fifo_full
    );

endinterface

// File: rtl/capture_ramp_gen.sv
// -----------------------------------------------------------------------------
// capture_ramp_gen
//   Ramp test-pattern counter. Holds the current ramp value; advances by one
//   on each accepted sample strobe and returns to zero on clear.
//   Ports:
//     dclk    : capture clock (rising edge)
//     rst     : synchronous reset, active-high
//     clear   : force ramp to 0 (takes priority over advance)
//     advance : increment ramp by one, wrapping at 2^DATA_W
//     ramp    : current ramp value
// -----------------------------------------------------------------------------
module capture_ramp_gen #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              dclk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [DATA_W-1:0] ramp
);

    always_ff @(posedge dclk) begin
        if (rst || clear) begin
            ramp <= '0;
        end else if (advance) begin
            ramp <= ramp + 1'b1;
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// -----------------------------------------------------------------------------
// capture_ctrl
//   Armed/triggered burst capture controller for the ADC capture path.
//   Delivers bursts of samples (ADC or ramp) to the write FIFO; samples that
//   meet a full FIFO are dropped and flagged, the burst never stalls.
//   Optional build macro CAPTURE_BURST_MARK_EN: when defined, data[DATA_W-1]
//   marks the first word of each burst and carries no sample bit.
//   Ports:
//     dclk, rst        : clock, synchronous active-high reset
//     arm              : pulse, IDLE -> ARMED; latches length/gap/mode
//     abort            : level, forces IDLE (highest priority)
//     trigger          : level, starts capture from ARMED
//     mode             : 0 = ADC samples, 1 = ramp test pattern
//     continuous       : re-run bursts until abort
//     burst_len        : samples per burst (0 selects BURST_LEN_DEF)
//     gap_len          : idle cycles between continuous bursts
//     adc_data/adc_valid : ADC sample input
//     fifo             : FIFO write bus (dv, data out; fifo_full in)
//     busy             : high in ARMED, CAPTURE or GAP
//     done             : one-cycle pulse with the last word of a single-shot burst
//     overflow         : sticky dropped-sample flag, cleared by arm or rst
//     burst_count      : bursts completed since arm
// -----------------------------------------------------------------------------
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned LEN_W         = 32,
    parameter int unsigned BURST_LEN_DEF = BURST_LEN_DEFAULT
) (
    input  logic                dclk,
    input  logic                rst,
    input  logic                arm,
    input  logic                abort,
    input  logic                trigger,
    input  logic                mode,
    input  logic                continuous,
    input  logic [LEN_W-1:0]    burst_len,
    input  logic [LEN_W-1:0]    gap_len,
    input  logic [DATA_W-1:0]   adc_data,
    input  logic                adc_valid,
    capture_ctrl_if.master      fifo,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [LEN_W-1:0]    burst_count
);

    localparam logic [LEN_W-1:0] LEN_DEF = LEN_W'(BURST_LEN_DEF);

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   gap_q;
    logic               mode_q;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   gap_cnt;
    logic               dv_q;
    logic [DATA_W-1:0]  data_q;

    logic               strobe;
    logic               last;
    logic               ramp_clr;
    logic [DATA_W-1:0]  ramp;
    logic [DATA_W-1:0]  sample;
    logic [DATA_W-1:0]  word;

    assign fifo.dv   = dv_q;
    assign fifo.data = data_q;

    assign strobe = (state == CAPTURE) && ((mode_q == MODE_RAMP) || adc_valid);
    // len_q is never 0, so the counter tops out at len_q-1 and cannot wrap.
    assign last   = strobe && (cnt == len_q - LEN_W'(1));

    // Ramp restarts at every burst start: on the trigger and on each burst end.
    assign ramp_clr = ((state == ARMED) && trigger) || last;

    capture_ramp_gen #(
        .DATA_W (DATA_W)
    ) u_ramp (
        .dclk    (dclk),
        .rst     (rst),
        .clear   (ramp_clr),
        .advance (strobe),
        .ramp    (ramp)
    );

    always_comb begin
        sample = (mode_q == MODE_RAMP) ? ramp : adc_data;
        word   = sample;
`ifdef CAPTURE_BURST_MARK_EN
        // Counter is 0 only on the first strobe of a burst; if that sample is
        // dropped the mark is lost with it.
        word[DATA_W-1] = (cnt == '0);
`endif
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= LEN_DEF;
            gap_q       <= '0;
            mode_q      <= MODE_ADC;
            cnt         <= '0;
            gap_cnt     <= '0;
            dv_q        <= 1'b0;
            data_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            burst_count <= '0;
        end else begin
            dv_q   <= 1'b0;
            data_q <= '0;
            done   <= 1'b0;

            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            state       <= ARMED;
                            busy        <= 1'b1;
                            len_q       <= (burst_len == '0) ? LEN_DEF : burst_len;
                            gap_q       <= gap_len;
                            mode_q      <= mode;
                            overflow    <= 1'b0;
                            burst_count <= '0;
                        end
                    end

                    ARMED: begin
                        if (trigger) begin
                            state <= CAPTURE;
                            cnt   <= '0;
                        end
                    end

                    CAPTURE: begin
                        if (strobe) begin
                            cnt <= cnt + LEN_W'(1);
                            if (fifo.fifo_full) begin
                                overflow <= 1'b1;
                            end else begin
                                dv_q   <= 1'b1;
                                data_q <= word;
                            end

                            if (last) begin
                                burst_count <= burst_count + LEN_W'(1);
                                cnt         <= '0;
                                if (!continuous) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else if (gap_q != '0) begin
                                    state   <= GAP;
                                    gap_cnt <= gap_q - LEN_W'(1);
                                end
                            end
                        end
                    end

                    GAP: begin
                        if (gap_cnt == '0) begin
                            state <= CAPTURE;
                        end else begin
                            gap_cnt <= gap_cnt - LEN_W'(1);
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_capture_ctrl
//   Directed self-checking bench for capture_ctrl. A 16-bit instance carries
//   the main scenarios; an 8-bit instance sharing the same stimulus checks the
//   ramp wrap over a default-length burst.
// -----------------------------------------------------------------------------
module tb_capture_ctrl;
    import capture_pkg::*;

`ifdef CAPTURE_BURST_MARK_EN
    localparam bit MARK = 1'b1;
`else
    localparam bit MARK = 1'b0;
`endif

    logic        dclk = 1'b0;
    logic        rst;
    logic        arm, abort, trigger, mode, continuous;
    logic [31:0] burst_len, gap_len;
    logic [15:0] adc_data;
    logic [7:0]  adc_data8;
    logic        adc_valid;
    logic        fifo_full;

    logic        busy, done, overflow;
    logic [31:0] burst_count;
    logic        busy8, done8, overflow8;
    logic [31:0] burst_count8;

    int n_vec = 0;
    int n_err = 0;

    always #5 dclk = ~dclk;

    capture_ctrl_if #(.DATA_W(16)) bus ();
    capture_ctrl_if #(.DATA_W(8))  bus8 ();

    assign bus.fifo_full  = fifo_full;
    assign bus8.fifo_full = fifo_full;
    assign adc_data8      = adc_data[7:0];

    capture_ctrl #(
        .DATA_W (16),
        .LEN_W  (32)
    ) u_dut (
        .dclk        (dclk),
        .rst         (rst),
        .arm         (arm),
        .abort       (abort),
        .trigger     (trigger),
        .mode        (mode),
        .continuous  (continuous),
        .burst_len   (burst_len),
        .gap_len     (gap_len),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .fifo        (bus),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .burst_count (burst_count)
    );

    capture_ctrl #(
        .DATA_W (8),
        .LEN_W  (32)
    ) u_dut8 (
        .dclk        (dclk),
        .rst         (rst),
        .arm         (arm),
        .abort       (abort),
        .trigger     (trigger),
        .mode        (mode),
        .continuous  (continuous),
        .burst_len   (burst_len),
        .gap_len     (gap_len),
        .adc_data    (adc_data8),
        .adc_valid   (adc_valid),
        .fifo        (bus8),
        .busy        (busy8),
        .done        (done8),
        .overflow    (overflow8),
        .burst_count (burst_count8)
    );

    // Per-cycle trace of the 16-bit instance, sampled mid-cycle.
    bit          rec = 1'b0;
    logic        tr_dv[$];
    logic [15:0] tr_data[$];
    logic        tr_done[$];
    logic        tr_vld[$];
    logic [15:0] words[$];
    int          widx[$];

    always @(negedge dclk) begin
        if (rec) begin
            tr_dv.push_back(bus.dv);
            tr_data.push_back(bus.data);
            tr_done.push_back(done);
            tr_vld.push_back(adc_valid);
        end
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp16(input int unsigned v, input bit first);
        logic [15:0] w;
        w = 16'(v);
        if (MARK) w[15] = first;
        return w;
    endfunction

    function automatic logic [7:0] exp8(input int unsigned v, input bit first);
        logic [7:0] w;
        w = 8'(v);
        if (MARK) w[7] = first;
        return w;
    endfunction

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic start_rec();
        tr_dv.delete(); tr_data.delete(); tr_done.delete(); tr_vld.delete();
        rec = 1'b1;
    endtask

    task automatic stop_rec();
        rec = 1'b0;
        words.delete(); widx.delete();
        foreach (tr_dv[k]) begin
            if (tr_dv[k] === 1'b1) begin
                words.push_back(tr_data[k]);
                widx.push_back(k);
            end
        end
    endtask

    task automatic arm_and_trigger();
        arm = 1'b1;     tick(); arm = 1'b0;
        trigger = 1'b1; tick(); trigger = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (!busy) break;
            tick();
        end
        check_vec(tag, busy, 1'b0);
    endtask

    // Index of the single done pulse in the trace (-1 if none), plus count.
    task automatic done_info(output int idx, output int cnt);
        idx = -1; cnt = 0;
        foreach (tr_done[k]) begin
            if (tr_done[k] === 1'b1) begin
                idx = k;
                cnt++;
            end
        end
    endtask

    initial begin
        int d_idx, d_cnt, viol;
        int n8, n16, bad8, bad16, dn;
        logic [15:0] bp_exp [5];
        bit          t4_dv [7];
        int          t4_val[7];
        bit          t4_fst[7];

        rst = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0; mode = MODE_RAMP;
        continuous = 1'b0; burst_len = 32'd8; gap_len = '0; adc_data = '0;
        adc_valid = 1'b0; fifo_full = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_vec("reset_outputs",
                  {bus.dv, bus.data, busy, done, overflow, burst_count},
                  '0);

        // ---- single-shot ramp, 8 words ----
        mode = MODE_RAMP; burst_len = 32'd8;
        start_rec();
        arm_and_trigger();
        wait_idle("t1_idle_wait", 50);
        tick();
        stop_rec();
        check_vec("t1_nwords", words.size(), 8);
        for (int i = 0; i < 8 && i < words.size(); i++)
            check_vec($sformatf("t1_word%0d", i), words[i], exp16(i, i == 0));
        if (words.size() == 8) check_vec("t1_contiguous", widx[7] - widx[0], 7);
        done_info(d_idx, d_cnt);
        check_vec("t1_done_cnt", d_cnt, 1);
        if (words.size() == 8) check_vec("t1_done_with_last", d_idx, widx[7]);
        check_vec("t1_burst_count", burst_count, 1);
        check_vec("t1_busy", busy, 0);

        // ---- ADC gated, valid on alternate cycles ----
        mode = MODE_ADC; burst_len = 32'd4;
        start_rec();
        arm_and_trigger();
        for (int i = 0; i < 4; i++) begin
            adc_valid = 1'b1; adc_data = 16'h00A0 + 16'(i); tick();
            adc_valid = 1'b0; adc_data = 16'h5555;          tick();
        end
        tick();
        stop_rec();
        check_vec("t2_nwords", words.size(), 4);
        for (int i = 0; i < 4 && i < words.size(); i++)
            check_vec($sformatf("t2_word%0d", i), words[i], exp16(32'hA0 + i, i == 0));
        viol = 0;
        foreach (tr_dv[k]) if (k > 0 && tr_dv[k] === 1'b1 && tr_vld[k-1] !== 1'b1) viol++;
        check_vec("t2_dv_follows_valid", viol, 0);
        done_info(d_idx, d_cnt);
        check_vec("t2_done_cnt", d_cnt, 1);
        if (words.size() == 4) check_vec("t2_done_with_last", d_idx, widx[3]);

        // ---- back-pressure on the 3rd strobe ----
        mode = MODE_RAMP; burst_len = 32'd6;
        start_rec();
        arm_and_trigger();
        tick(); tick();
        fifo_full = 1'b1; tick();
        fifo_full = 1'b0;
        wait_idle("t3_idle_wait", 20);
        tick();
        stop_rec();
        bp_exp = '{exp16(0, 1), exp16(1, 0), exp16(3, 0), exp16(4, 0), exp16(5, 0)};
        check_vec("t3_nwords", words.size(), 5);
        for (int i = 0; i < 5 && i < words.size(); i++)
            check_vec($sformatf("t3_word%0d", i), words[i], bp_exp[i]);
        check_vec("t3_overflow_set", overflow, 1);
        repeat (5) tick();
        check_vec("t3_overflow_sticky", overflow, 1);
        arm = 1'b1; tick(); arm = 1'b0;
        check_vec("t3_overflow_cleared_by_arm", overflow, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        check_vec("t3_abort_from_armed", busy, 0);

        // ---- continuous, gap 2, abort on last strobe of 2nd burst ----
        burst_len = 32'd3; gap_len = 32'd2; continuous = 1'b1;
        t4_dv  = '{1, 1, 1, 0, 0, 1, 1};
        t4_val = '{0, 1, 2, 0, 0, 0, 1};
        t4_fst = '{1, 0, 0, 0, 0, 1, 0};
        arm_and_trigger();
        for (int t = 0; t < 7; t++) begin
            tick();
            check_vec($sformatf("t4_dv_c%0d", t), bus.dv, t4_dv[t]);
            check_vec($sformatf("t4_data_c%0d", t), bus.data,
                      t4_dv[t] ? exp16(t4_val[t], t4_fst[t]) : 16'h0000);
            if (t == 2) check_vec("t4_count_after_burst1", burst_count, 1);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        check_vec("t4_abort_dv", bus.dv, 0);
        check_vec("t4_abort_count", burst_count, 1);
        check_vec("t4_abort_busy", busy, 0);
        check_vec("t4_abort_no_done", done, 0);

        // ---- continuous, gap 0: back-to-back bursts ----
        burst_len = 32'd2; gap_len = '0;
        arm_and_trigger();
        for (int t = 0; t < 5; t++) begin
            tick();
            check_vec($sformatf("t5_dv_c%0d", t), bus.dv, 1);
            check_vec($sformatf("t5_data_c%0d", t), bus.data, exp16(t % 2, (t % 2) == 0));
            if (t == 3) check_vec("t5_count", burst_count, 2);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        continuous = 1'b0;

        // ---- burst_len = 0 selects 16384, ramp wraps on the 8-bit build ----
        burst_len = '0;
        arm_and_trigger();
        n8 = 0; n16 = 0; bad8 = 0; bad16 = 0; dn = 0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (bus8.dv === 1'b1) begin
                if (bus8.data !== exp8(n8, n8 == 0)) bad8++;
                n8++;
            end
            if (bus.dv === 1'b1) begin
                if (bus.data !== exp16(n16, n16 == 0)) bad16++;
                n16++;
            end
            if (done === 1'b1) dn++;
            if (!busy) break;
        end
        check_vec("t6_busy_end", busy, 0);
        check_vec("t6_nwords_w8", n8, 16384);
        check_vec("t6_bad_w8", bad8, 0);
        check_vec("t6_nwords_w16", n16, 16384);
        check_vec("t6_bad_w16", bad16, 0);
        check_vec("t6_done_cnt", dn, 1);
        check_vec("t6_burst_count", burst_count, 1);

        // ---- rst in the middle of a capture ----
        burst_len = 32'd8;
        arm_and_trigger();
        fifo_full = 1'b1; tick();
        fifo_full = 1'b0; tick(); tick();
        check_vec("t7_pre_rst_dv", bus.dv, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_vec("t7_rst_outputs",
                  {bus.dv, bus.data, busy, done, overflow, burst_count},
                  '0);
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.dv !== 1'b0) viol++;
        end
        check_vec("t7_no_dv_after_rst", viol, 0);

        // ---- trigger held in IDLE, arm+abort together ----
        trigger = 1'b1;
        viol = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.dv !== 1'b0 || busy !== 1'b0) viol++;
        end
        trigger = 1'b0;
        check_vec("t8_trigger_in_idle", viol, 0);
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        check_vec("t8_arm_abort_same_cycle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
